lin_norm_sequencer: RTL

LIN_NORM_SEQUENCER -- requirements
Module: lin_norm_sequencer

---
 rtl/lin_norm_sequencer.sv | 119 +++++++++++
 1 files changed

// File: rtl/lin_norm_sequencer.sv
// Sequencer for the current/voltage linearizer-normalizer datapath: captures operands,
// pulses the datapath reset, collects both results once each. Optional watchdog: LIN_NORM_SEQ_WATCHDOG_EN.
module lin_norm_sequencer #(
   parameter int unsigned W              = 32,
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic         CLK,
   input  logic         RST_SEQ,
   input  logic         START,
   input  logic [W-1:0] I_IN,
   input  logic [W-1:0] V_IN,
   output logic         BUSY,
   output logic         DONE,
   output logic         ERR,
   output logic [W-1:0] I_OUT,
   output logic [W-1:0] V_OUT,
   output logic         RST_DP,
   output logic         BEGIN_I,
   output logic         BEGIN_V,
   output logic [W-1:0] OP_I,
   output logic [W-1:0] OP_V,
   input  logic         ACK_I,
   input  logic         ACK_V,
   input  logic [W-1:0] RESULT_I,
   input  logic [W-1:0] RESULT_V
);

   typedef enum logic [2:0] {S_IDLE, S_CLR, S_WAIT, S_FIN, S_ABORT} state_t;

   if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
      $error("TIMEOUT_CYCLES out of range 1..65535");
   end

   state_t       state_q;
   logic         got_i_q, got_v_q;
   logic         got_i_d, got_v_d;
   logic         latch_i, latch_v;
   logic [W-1:0] i_out_q, v_out_q, op_i_q, op_v_q;

   // A result is taken only on its first acknowledge inside WAIT.
   assign latch_i = (state_q == S_WAIT) && ACK_I && !got_i_q;
   assign latch_v = (state_q == S_WAIT) && ACK_V && !got_v_q;
   assign got_i_d = got_i_q || latch_i;
   assign got_v_d = got_v_q || latch_v;

`ifdef LIN_NORM_SEQ_WATCHDOG_EN
   logic [15:0] wd_q;
   logic        expire;
   assign expire = (wd_q == 16'(TIMEOUT_CYCLES - 1));
`endif

   always_ff @(posedge CLK) begin
      if (RST_SEQ) begin
         state_q <= S_IDLE;
         got_i_q <= 1'b0;
         got_v_q <= 1'b0;
         i_out_q <= '0;
         v_out_q <= '0;
         op_i_q  <= '0;
         op_v_q  <= '0;
`ifdef LIN_NORM_SEQ_WATCHDOG_EN
         wd_q    <= '0;
`endif
      end else begin
         case (state_q)
            S_IDLE: begin
               if (START) begin
                  op_i_q  <= I_IN;
                  op_v_q  <= V_IN;
                  state_q <= S_CLR;
               end
            end
            S_CLR: begin
               got_i_q <= 1'b0;
               got_v_q <= 1'b0;
`ifdef LIN_NORM_SEQ_WATCHDOG_EN
               wd_q    <= '0;
`endif
               state_q <= S_WAIT;
            end
            S_WAIT: begin
               if (latch_i) i_out_q <= RESULT_I;
               if (latch_v) v_out_q <= RESULT_V;
               got_i_q <= got_i_d;
               got_v_q <= got_v_d;
`ifdef LIN_NORM_SEQ_WATCHDOG_EN
               wd_q    <= wd_q + 16'd1;
               // Completion on the final allowed cycle wins over the timeout.
               if (got_i_d && got_v_d) state_q <= S_FIN;
               else if (expire)        state_q <= S_ABORT;
`else
               if (got_i_d && got_v_d) state_q <= S_FIN;
`endif
            end
            S_FIN:   state_q <= S_IDLE;
            S_ABORT: state_q <= S_IDLE;
            default: state_q <= S_IDLE;
         endcase
      end
   end

   // Strobes are decoded from state and forced inactive while reset is held.
   assign BUSY    = !RST_SEQ && (state_q != S_IDLE);
   assign DONE    = !RST_SEQ && (state_q == S_FIN);
   assign RST_DP  = RST_SEQ || (state_q == S_CLR) || (state_q == S_ABORT);
   assign BEGIN_I = !RST_SEQ && (state_q == S_WAIT) && !got_i_q;
   assign BEGIN_V = !RST_SEQ && (state_q == S_WAIT) && !got_v_q;
`ifdef LIN_NORM_SEQ_WATCHDOG_EN
   assign ERR     = !RST_SEQ && (state_q == S_ABORT);
`else
   assign ERR     = 1'b0;
`endif

   assign I_OUT = i_out_q;
   assign V_OUT = v_out_q;
   assign OP_I  = op_i_q;
   assign OP_V  = op_v_q;

endmodule
